edge_pulse_extender: RTL and testbench
======================================

// Module: edge_pulse_extender
// PURPOSE
//  Multi-channel edge-triggered pulse stretcher in the fast clk domain.
//  Synchronises NUM_CH slow strobes/clocks, detects the selected edge, emits a pulse of runtime length.
//  Adds per-channel enable, retrigger, hold-off and missed-edge reporting.
//  Sits between slow data-clock/reset sources and the OFDM PHY datapath resets/enables.
// PARAMETERS
//  NUM_CH       4  number of independent channels
//  CNT_W        6  width of length counter; max pulse = 2^CNT_W-1 cycles
//  SYNC_STAGES  2  input synchroniser flops, 0..3; 0 = input used directly
//  EDGE_MODE    0  0 rising, 1 falling, 2 both edges
//  HOLDOFF_CYC  0  post-pulse lockout cycles, 0..2^CNT_W-1; edges ignored
// PORTS
//  clk        in   1       single clock, all logic posedge
//  rst_n      in   1       asynchronous, active-low reset
//  sig_in     in   NUM_CH  slow strobe/clock per channel, async to clk
//  ch_en      in   NUM_CH  per-channel enable, sampled every cycle
//  len_cfg    in   CNT_W   pulse length in cycles, shared, latched per channel at trigger
//  retrig_en  in   1       1: edge during ACTIVE reloads counter
//  pulse_out  out  NUM_CH  stretched pulse, registered
//  start_stb  out  NUM_CH  1-cycle strobe on first cycle of each new pulse, not on reload
//  edge_miss  out  NUM_CH  1-cycle strobe when a detected edge is dropped
//  pulse_any  out  1       registered OR of next-state pulse_out; equals |pulse_out every cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): all sync flops, prev flop, counters, states = 0/IDLE.
//   All outputs 0.
//  prev resets to 0: input held high at reset release gives one rising edge after sync.
//  Sync chain s = sig_in after SYNC_STAGES flops; prev = s delayed 1 cycle.
//   Edge at cycle n: rise = s&~prev, fall = ~s&prev.
//  FSM per channel: IDLE, ACTIVE, HOLDOFF.
//   IDLE: edge & ch_en & len_cfg!=0 -> ACTIVE, cnt<=len_cfg-1.
//    pulse_out=1 and start_stb=1 from cycle n+1.
//    Pulse lasts exactly len_cfg cycles.
//   IDLE: edge & len_cfg==0 -> stay IDLE, edge_miss=1 at n+1.
//   ACTIVE: cnt decrements each cycle while cnt!=0; pulse_out=1.
//   ACTIVE, cnt==0, no reload -> HOLDOFF with hcnt<=HOLDOFF_CYC-1 if HOLDOFF_CYC>0, else IDLE.
//    pulse_out=0 next cycle.
//   ACTIVE edge, retrig_en=1, len_cfg!=0: cnt<=len_cfg-1, includes cnt==0 cycle.
//    Pulse continues seamlessly; no start_stb.
//   ACTIVE edge, retrig_en=0 or len_cfg==0: dropped, edge_miss=1 next cycle.
//   HOLDOFF: pulse_out=0; edges dropped with edge_miss; hcnt==0 -> IDLE.
//   IDLE edge on the cycle HOLDOFF exits is not possible; the edge is evaluated in HOLDOFF and dropped.
//  ch_en=0: channel -> IDLE next cycle, pulse_out=0, edges ignored without edge_miss.
//   Sync/prev keep running, so no stale edge on re-enable.
//  Latency sig_in -> pulse_out: SYNC_STAGES+1 cycles; 2 clk edges min input pulse width.
//  Counters saturate-free: decrement only while nonzero, no wrap.
//  Mid-operation reset: pulse aborts immediately, async; no strobes on release.
// STRUCTURE
//  Package edge_ext_pkg: state encodings, EDGE_RISE/FALL/BOTH constants.
//  Sub-module edge_pulse_extender_ch: one channel, contains sync, edge detect, FSM, counters.
//  Top generates NUM_CH instances, ORs pulse_any.
// TESTING
//  T1: SYNC=2, len_cfg=5, rise on ch0 -> pulse_out[0] high cycles n+1..n+5, start_stb once, 3-cycle latency.
//  T2: retrig_en=1, 2nd rise 3 cycles in (len 5) -> one continuous 8-cycle pulse, one start_stb, no miss.
//  T3: retrig_en=0, same stimulus -> 5-cycle pulse, edge_miss=1 one cycle.
//  T4: HOLDOFF_CYC=4, edge 2 cycles after pulse end -> dropped with edge_miss; edge after 4 cycles -> new pulse.
//  T5: EDGE_MODE=2, len 2, sig_in toggles every 10 cycles -> pulse per toggle; len_cfg=0 -> only edge_miss.
//  T6: rst_n low mid-pulse -> outputs 0 same cycle; sig_in high at release -> one pulse after sync; ch_en=0 kills pulse next cycle.

Source files
------------

// File: rtl/edge_pulse_extender_pkg.sv
// -----------------------------------------------------------------------------
// edge_ext_pkg
//   Shared definitions for the multi-channel edge pulse extender:
//   per-channel FSM state encoding, edge-mode selector constants and the
//   edge-select helper used by every channel.
// -----------------------------------------------------------------------------
package edge_ext_pkg;

  // Per-channel controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } ch_state_e;

  // Edge-mode selector values.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Returns 1 when the synchronised level s, compared with its value one
  // cycle earlier (prev), shows an edge of the selected kind.
  function automatic logic edge_sel(input logic s, input logic prev, input int mode);
    if (mode == EDGE_FALL)      return ~s & prev;
    else if (mode == EDGE_BOTH) return s ^ prev;
    else                        return s & ~prev;
  endfunction

endpackage : edge_ext_pkg

// File: rtl/edge_pulse_extender_ch.sv
// -----------------------------------------------------------------------------
// edge_pulse_extender_ch
//   One channel of the pulse extender: input synchroniser, edge detector,
//   IDLE/ACTIVE/HOLDOFF controller with length and hold-off counters.
//
// Ports
//   clk          in   fast clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   sig_i        in   slow strobe / clock, asynchronous to clk
//   ch_en_i      in   channel enable, synchronous to clk
//   len_cfg_i    in   pulse length in cycles, latched at trigger
//   retrig_en_i  in   edge during ACTIVE reloads the length counter
//   pulse_o      out  stretched pulse, registered
//   start_stb_o  out  1-cycle strobe on the first cycle of a new pulse
//   edge_miss_o  out  1-cycle strobe when a detected edge is dropped
//   pulse_nxt_o  out  next-state value of pulse_o (feeds the top-level OR)
// -----------------------------------------------------------------------------
module edge_pulse_extender_ch
  import edge_ext_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int HOLDOFF_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic             ch_en_i,
  input  logic [CNT_W-1:0] len_cfg_i,
  input  logic             retrig_en_i,
  output logic             pulse_o,
  output logic             start_stb_o,
  output logic             edge_miss_o,
  output logic             pulse_nxt_o
);

  // Hold-off reload value; only meaningful when HOLDOFF_CYC > 0.
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLDOFF_CYC > 0) ? CNT_W'(HOLDOFF_CYC - 1) : '0;

  logic s;

  // ---------------------------------------------------------------------------
  // Input synchroniser (bypassed entirely when SYNC_STAGES == 0)
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = sig_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= sig_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Edge detect. prev resets low, so an input already high at reset release
  // is seen as one rising edge once it has crossed the synchroniser.
  // ---------------------------------------------------------------------------
  logic prev_q;
  logic edge_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= s;
  end

  assign edge_hit = edge_sel(s, prev_q, EDGE_MODE);

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             pulse_q, pulse_d;
  logic             start_q, start_d;
  logic             miss_q, miss_d;
  logic             len_zero;
  logic [CNT_W-1:0] len_load;

  assign len_zero = (len_cfg_i == '0);
  assign len_load = len_cfg_i - CNT_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case tree leaves it unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    start_d = 1'b0;
    miss_d  = 1'b0;

    if (!ch_en_i) begin
      // Disabled: abort silently; edges are neither used nor reported.
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (edge_hit) begin
            if (len_zero) begin
              miss_d = 1'b1;
            end else begin
              state_d = ST_ACTIVE;
              cnt_d   = len_load;
              start_d = 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (edge_hit && retrig_en_i && !len_zero) begin
            // Reload takes priority over expiry, including the cnt==0 cycle,
            // so the pulse continues without a gap or a new start strobe.
            cnt_d = len_load;
          end else begin
            if (edge_hit) miss_d = 1'b1;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (HOLDOFF_CYC > 0) begin
              state_d = ST_HOLDOFF;
              hcnt_d  = HOLD_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_HOLDOFF: begin
          // Edges are dropped here, including on the exit cycle.
          if (edge_hit) miss_d = 1'b1;
          if (hcnt_q != '0) hcnt_d  = hcnt_q - CNT_W'(1);
          else              state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    pulse_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      pulse_q <= 1'b0;
      start_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      pulse_q <= pulse_d;
      start_q <= start_d;
      miss_q  <= miss_d;
    end
  end

  assign pulse_o     = pulse_q;
  assign start_stb_o = start_q;
  assign edge_miss_o = miss_q;
  assign pulse_nxt_o = pulse_d;

endmodule : edge_pulse_extender_ch

// File: rtl/edge_pulse_extender.sv
// -----------------------------------------------------------------------------
// edge_pulse_extender
//   Multi-channel edge-triggered pulse stretcher. Each channel synchronises a
//   slow strobe, detects the selected edge and emits a pulse of runtime length,
//   with enable, retrigger, hold-off and missed-edge reporting.
//
// Ports
//   clk        in   single clock, all logic posedge
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   [NUM_CH] slow strobe/clock per channel, async to clk
//   ch_en      in   [NUM_CH] per-channel enable
//   len_cfg    in   [CNT_W]  pulse length, latched per channel at trigger
//   retrig_en  in   edge during ACTIVE reloads the counter
//   pulse_out  out  [NUM_CH] stretched pulse, registered
//   start_stb  out  [NUM_CH] strobe on first cycle of each new pulse
//   edge_miss  out  [NUM_CH] strobe when a detected edge is dropped
//   pulse_any  out  registered OR of all channels, equals |pulse_out
// -----------------------------------------------------------------------------
module edge_pulse_extender
  import edge_ext_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int HOLDOFF_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [CNT_W-1:0]  len_cfg,
  input  logic              retrig_en,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] start_stb,
  output logic [NUM_CH-1:0] edge_miss,
  output logic              pulse_any
);

  logic [NUM_CH-1:0] pulse_nxt;
  logic              pulse_any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_pulse_extender_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE),
      .HOLDOFF_CYC (HOLDOFF_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .sig_i       (sig_in[g]),
      .ch_en_i     (ch_en[g]),
      .len_cfg_i   (len_cfg),
      .retrig_en_i (retrig_en),
      .pulse_o     (pulse_out[g]),
      .start_stb_o (start_stb[g]),
      .edge_miss_o (edge_miss[g]),
      .pulse_nxt_o (pulse_nxt[g])
    );
  end

  // Registering the OR of next-state pulses keeps pulse_any cycle-aligned
  // with pulse_out while still coming straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_any_q <= 1'b0;
    else        pulse_any_q <= |pulse_nxt;
  end

  assign pulse_any = pulse_any_q;

endmodule : edge_pulse_extender

// File: tb/tb_edge_pulse_extender.sv
// -----------------------------------------------------------------------------
// tb_edge_pulse_extender
//   Directed bench for edge_pulse_extender. Three instances share stimulus:
//     dut_a : rising edge, no hold-off
//     dut_b : rising edge, HOLDOFF_CYC = 4
//     dut_c : both edges,  HOLDOFF_CYC = 4
//   Inputs are driven and outputs sampled on the falling clock edge. Traces
//   are indexed by falling edge t after the stimulus pattern starts; bit t of
//   a pattern is driven at falling edge t.
// -----------------------------------------------------------------------------
module tb_edge_pulse_extender;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] ch_en;
  logic [CNT_W-1:0]  len_cfg;
  logic              retrig_en;

  logic [NUM_CH-1:0] a_pulse_out, a_start_stb, a_edge_miss;
  logic [NUM_CH-1:0] b_pulse_out, b_start_stb, b_edge_miss;
  logic [NUM_CH-1:0] c_pulse_out, c_start_stb, c_edge_miss;
  logic              a_pulse_any, b_pulse_any, c_pulse_any;

  int checks   = 0;
  int failures = 0;

  logic [31:0] a_pulse_tr, a_start_tr, a_miss_tr, a_any_tr, a_other_tr;
  logic [31:0] b_pulse_tr, b_start_tr, b_miss_tr;
  logic [31:0] c_pulse_tr, c_start_tr, c_miss_tr;

  always #5 clk = ~clk;

  edge_pulse_extender #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2),
                        .EDGE_MODE(0), .HOLDOFF_CYC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .len_cfg(len_cfg),
    .retrig_en(retrig_en), .pulse_out(a_pulse_out), .start_stb(a_start_stb),
    .edge_miss(a_edge_miss), .pulse_any(a_pulse_any));

  edge_pulse_extender #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2),
                        .EDGE_MODE(0), .HOLDOFF_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .len_cfg(len_cfg),
    .retrig_en(retrig_en), .pulse_out(b_pulse_out), .start_stb(b_start_stb),
    .edge_miss(b_edge_miss), .pulse_any(b_pulse_any));

  edge_pulse_extender #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2),
                        .EDGE_MODE(2), .HOLDOFF_CYC(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .len_cfg(len_cfg),
    .retrig_en(retrig_en), .pulse_out(c_pulse_out), .start_stb(c_start_stb),
    .edge_miss(c_edge_miss), .pulse_any(c_pulse_any));

  // Reset everything, release on a falling edge, settle with inputs low.
  task automatic apply_reset();
    rst_n     = 1'b0;
    sig_in    = '0;
    ch_en     = '1;
    len_cfg   = 6'd5;
    retrig_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Drive channel 0 from the patterns and record per-edge output traces.
  // Must be called on a falling edge.
  task automatic capture(input logic [31:0] sig_pat, input logic [31:0] en_pat, input int n);
    a_pulse_tr = '0; a_start_tr = '0; a_miss_tr = '0; a_any_tr = '0; a_other_tr = '0;
    b_pulse_tr = '0; b_start_tr = '0; b_miss_tr = '0;
    c_pulse_tr = '0; c_start_tr = '0; c_miss_tr = '0;
    for (int t = 0; t < n; t++) begin
      if (t != 0) @(negedge clk);
      a_pulse_tr[t] = a_pulse_out[0];
      a_start_tr[t] = a_start_stb[0];
      a_miss_tr[t]  = a_edge_miss[0];
      a_any_tr[t]   = a_pulse_any;
      a_other_tr[t] = (|a_pulse_out[3:1]) | (|a_start_stb[3:1]) | (|a_edge_miss[3:1]);
      b_pulse_tr[t] = b_pulse_out[0];
      b_start_tr[t] = b_start_stb[0];
      b_miss_tr[t]  = b_edge_miss[0];
      c_pulse_tr[t] = c_pulse_out[0];
      c_start_tr[t] = c_start_stb[0];
      c_miss_tr[t]  = c_edge_miss[0];
      sig_in[0] = sig_pat[t];
      ch_en[0]  = en_pat[t];
    end
  endtask

  // All outputs low while reset is held, even with every input high.
  task automatic test_reset();
    rst_n     = 1'b0;
    sig_in    = '1;
    ch_en     = '1;
    len_cfg   = 6'd5;
    retrig_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_pulse_out, a_start_stb, a_edge_miss, a_pulse_any} !== 13'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {a_pulse_out, a_start_stb, a_edge_miss, a_pulse_any});
    end
    checks++;
    if ({b_pulse_out, b_start_stb, b_edge_miss, b_pulse_any} !== 13'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", {b_pulse_out, b_start_stb, b_edge_miss, b_pulse_any});
    end
    checks++;
    if ({c_pulse_out, c_start_stb, c_edge_miss, c_pulse_any} !== 13'h0) begin
      failures++;
      $display("FAIL reset_c got=%h exp=0", {c_pulse_out, c_start_stb, c_edge_miss, c_pulse_any});
    end
  endtask

  // T1: single rise, len 5: pulse at t=3..7, one start strobe, no miss.
  task automatic test_basic();
    apply_reset();
    capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16);
    checks++;
    if (a_pulse_tr !== 32'h0000_00F8) begin
      failures++; $display("FAIL t1_pulse got=%h exp=%h", a_pulse_tr, 32'h0000_00F8);
    end
    checks++;
    if (a_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t1_start got=%h exp=%h", a_start_tr, 32'h0000_0008);
    end
    checks++;
    if (a_miss_tr !== 32'h0) begin
      failures++; $display("FAIL t1_miss got=%h exp=0", a_miss_tr);
    end
    checks++;
    if (a_any_tr !== 32'h0000_00F8) begin
      failures++; $display("FAIL t1_any got=%h exp=%h", a_any_tr, 32'h0000_00F8);
    end
    checks++;
    if (a_other_tr !== 32'h0) begin
      failures++; $display("FAIL t1_other_ch got=%h exp=0", a_other_tr);
    end
  endtask

  // T2: second rise 3 cycles in with retrigger: one continuous 8-cycle pulse.
  task automatic test_retrig();
    apply_reset();
    retrig_en = 1'b1;
    capture(32'hFFFF_FFFB, 32'hFFFF_FFFF, 16);
    checks++;
    if (a_pulse_tr !== 32'h0000_07F8) begin
      failures++; $display("FAIL t2_pulse got=%h exp=%h", a_pulse_tr, 32'h0000_07F8);
    end
    checks++;
    if (a_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t2_start got=%h exp=%h", a_start_tr, 32'h0000_0008);
    end
    checks++;
    if (a_miss_tr !== 32'h0) begin
      failures++; $display("FAIL t2_miss got=%h exp=0", a_miss_tr);
    end
    checks++;
    if (a_any_tr !== 32'h0000_07F8) begin
      failures++; $display("FAIL t2_any got=%h exp=%h", a_any_tr, 32'h0000_07F8);
    end
  endtask

  // T3: same stimulus without retrigger: 5-cycle pulse, second edge missed.
  task automatic test_no_retrig();
    apply_reset();
    retrig_en = 1'b0;
    capture(32'hFFFF_FFFB, 32'hFFFF_FFFF, 16);
    checks++;
    if (a_pulse_tr !== 32'h0000_00F8) begin
      failures++; $display("FAIL t3_pulse got=%h exp=%h", a_pulse_tr, 32'h0000_00F8);
    end
    checks++;
    if (a_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t3_start got=%h exp=%h", a_start_tr, 32'h0000_0008);
    end
    checks++;
    if (a_miss_tr !== 32'h0000_0040) begin
      failures++; $display("FAIL t3_miss got=%h exp=%h", a_miss_tr, 32'h0000_0040);
    end
  endtask

  // T4: hold-off of 4 (t=8..11). Edge evaluated at t=9 dropped, edge at t=12
  // starts a new pulse. Then an edge on the hold-off exit cycle (t=11) drops.
  task automatic test_holdoff();
    apply_reset();
    capture(32'hFFFF_FD9F, 32'hFFFF_FFFF, 24);
    checks++;
    if (b_pulse_tr !== 32'h0003_E0F8) begin
      failures++; $display("FAIL t4_pulse got=%h exp=%h", b_pulse_tr, 32'h0003_E0F8);
    end
    checks++;
    if (b_start_tr !== 32'h0000_2008) begin
      failures++; $display("FAIL t4_start got=%h exp=%h", b_start_tr, 32'h0000_2008);
    end
    checks++;
    if (b_miss_tr !== 32'h0000_0400) begin
      failures++; $display("FAIL t4_miss got=%h exp=%h", b_miss_tr, 32'h0000_0400);
    end

    apply_reset();
    capture(32'hFFFF_FE1F, 32'hFFFF_FFFF, 24);
    checks++;
    if (b_pulse_tr !== 32'h0000_00F8) begin
      failures++; $display("FAIL t4_exit_pulse got=%h exp=%h", b_pulse_tr, 32'h0000_00F8);
    end
    checks++;
    if (b_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t4_exit_start got=%h exp=%h", b_start_tr, 32'h0000_0008);
    end
    checks++;
    if (b_miss_tr !== 32'h0000_1000) begin
      failures++; $display("FAIL t4_exit_miss got=%h exp=%h", b_miss_tr, 32'h0000_1000);
    end
  endtask

  // T5: both-edge mode, len 2, toggle every 10 cycles: a pulse per toggle.
  // With len 0 every edge only reports a miss.
  task automatic test_both_edges();
    apply_reset();
    len_cfg = 6'd2;
    capture(32'h3FF0_03FF, 32'hFFFF_FFFF, 32);
    checks++;
    if (c_pulse_tr !== 32'h0180_6018) begin
      failures++; $display("FAIL t5_pulse got=%h exp=%h", c_pulse_tr, 32'h0180_6018);
    end
    checks++;
    if (c_start_tr !== 32'h0080_2008) begin
      failures++; $display("FAIL t5_start got=%h exp=%h", c_start_tr, 32'h0080_2008);
    end
    checks++;
    if (c_miss_tr !== 32'h0) begin
      failures++; $display("FAIL t5_miss got=%h exp=0", c_miss_tr);
    end

    apply_reset();
    len_cfg = 6'd0;
    capture(32'h3FF0_03FF, 32'hFFFF_FFFF, 32);
    checks++;
    if (c_pulse_tr !== 32'h0) begin
      failures++; $display("FAIL t5_len0_pulse got=%h exp=0", c_pulse_tr);
    end
    checks++;
    if (c_start_tr !== 32'h0) begin
      failures++; $display("FAIL t5_len0_start got=%h exp=0", c_start_tr);
    end
    checks++;
    if (c_miss_tr !== 32'h0080_2008) begin
      failures++; $display("FAIL t5_len0_miss got=%h exp=%h", c_miss_tr, 32'h0080_2008);
    end
  endtask

  // T6: asynchronous reset mid-pulse, then one pulse from an input held high
  // through release, then ch_en=0 kills a pulse with no stale edge afterwards.
  task automatic test_reset_and_enable();
    apply_reset();
    capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    checks++;
    if (a_pulse_out[0] !== 1'b1) begin
      failures++; $display("FAIL t6_pre_rst_pulse got=%b exp=1", a_pulse_out[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_pulse_out, a_start_stb, a_edge_miss, a_pulse_any} !== 13'h0) begin
      failures++;
      $display("FAIL t6_async_rst got=%h exp=0", {a_pulse_out, a_start_stb, a_edge_miss, a_pulse_any});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 12);
    checks++;
    if (a_pulse_tr !== 32'h0000_00F8) begin
      failures++; $display("FAIL t6_release_pulse got=%h exp=%h", a_pulse_tr, 32'h0000_00F8);
    end
    checks++;
    if (a_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t6_release_start got=%h exp=%h", a_start_tr, 32'h0000_0008);
    end

    apply_reset();
    capture(32'hFFFF_FFDF, 32'hFFFF_FC0F, 16);
    checks++;
    if (a_pulse_tr !== 32'h0000_0018) begin
      failures++; $display("FAIL t6_en_pulse got=%h exp=%h", a_pulse_tr, 32'h0000_0018);
    end
    checks++;
    if (a_start_tr !== 32'h0000_0008) begin
      failures++; $display("FAIL t6_en_start got=%h exp=%h", a_start_tr, 32'h0000_0008);
    end
    checks++;
    if (a_miss_tr !== 32'h0) begin
      failures++; $display("FAIL t6_en_miss got=%h exp=0", a_miss_tr);
    end
    checks++;
    if (a_any_tr !== 32'h0000_0018) begin
      failures++; $display("FAIL t6_en_any got=%h exp=%h", a_any_tr, 32'h0000_0018);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retrig();
    test_no_retrig();
    test_holdoff();
    test_both_edges();
    test_reset_and_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule : tb_edge_pulse_extender
